// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the 4-input truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] F_MINTERMS = 16'hAA45;
    localparam int          N_VEC      = 16;
    localparam int          IDX_W      = 4;

endpackage

// File: rtl/truth_table_sweeper_sweep_counter.sv
// Vector index and settle counters with terminal-count flags.
module sweep_counter
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             settle_en_i,
    input  logic             advance_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             settle_tc_o,
    output logic             last_vec_o
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       settle_q, settle_d;

    assign settle_tc_o = (settle_q == SETTLE_LAST);
    assign last_vec_o  = (idx_q == IDX_W'(N_VEC - 1));
    assign idx_o       = idx_q;

    always_comb begin
        idx_d    = idx_q;
        settle_d = settle_q;
        if (clear_i) begin
            idx_d    = '0;
            settle_d = '0;
        end else if (advance_i) begin
            // Index wraps to 0 after the last vector; the FSM never reuses it.
            idx_d    = idx_q + IDX_W'(1);
            settle_d = '0;
        end else if (settle_en_i) begin
            settle_d = settle_tc_o ? 4'd0 : settle_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q    <= '0;
            settle_q <= '0;
        end else begin
            idx_q    <= idx_d;
            settle_q <= settle_d;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 {a,b,c,d} vectors, samples two implementations after a settle
// time, and reports the captured truth table, equivalence and golden match.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int          SETTLE   = 1,
    parameter logic [15:0] EXPECTED = F_MINTERMS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f_in,
    input  logic        g_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  mismatch_cnt,
    output logic        fail_valid,
    output logic [3:0]  first_fail,
    output logic        pass
);

    state_t           state_q, state_d;
    logic [15:0]      tt_q, tt_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             fv_q, fv_d;
    logic [3:0]       ff_q, ff_d;
    logic             pass_q, pass_d;

    logic             clear, settle_en, advance;
    logic [IDX_W-1:0] idx;
    logic             settle_tc, last_vec;
    logic             vec_fail;

    sweep_counter #(.SETTLE(SETTLE)) u_cnt (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .settle_en_i (settle_en),
        .advance_i   (advance),
        .idx_o       (idx),
        .settle_tc_o (settle_tc),
        .last_vec_o  (last_vec)
    );

    // The stimulus is the registered index itself, a as MSB.
    assign {a, b, c, d} = idx;

    assign vec_fail = (f_in != g_in) || (f_in != EXPECTED[idx]);

    always_comb begin
        state_d   = state_q;
        tt_d      = tt_q;
        cnt_d     = cnt_q;
        fv_d      = fv_q;
        ff_d      = ff_q;
        pass_d    = pass_q;
        clear     = 1'b0;
        settle_en = 1'b0;
        advance   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    clear   = 1'b1;
                    tt_d    = '0;
                    cnt_d   = '0;
                    fv_d    = 1'b0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                settle_en = 1'b1;
                if (settle_tc) state_d = SAMPLE;
            end
            SAMPLE: begin
                advance   = 1'b1;
                tt_d[idx] = f_in;
                if (f_in != g_in) cnt_d = cnt_q + 5'd1;
                if (vec_fail && !fv_q) begin
                    fv_d = 1'b1;
                    ff_d = idx;
                end
                if (last_vec) begin
                    state_d = DONE;
                    // Verdict lands together with the final capture so it is valid with done.
                    pass_d  = (tt_d == EXPECTED) && (cnt_d == 5'd0);
                end else begin
                    state_d = DRIVE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tt_q    <= '0;
            cnt_q   <= '0;
            fv_q    <= 1'b0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tt_q    <= tt_d;
            cnt_q   <= cnt_d;
            fv_q    <= fv_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    assign busy         = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done         = (state_q == DONE);
    assign truth_table  = tt_q;
    assign mismatch_cnt = cnt_q;
    assign fail_valid   = fv_q;
    assign first_fail   = ff_q;
    assign pass         = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: table of fault modes on a SETTLE=1 sweeper, plus hand-written
// sequences for SETTLE=3 timing, mid-sweep reset and back-to-back sweeps.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start0, start1;
    logic        a0, b0, c0, d0, f0, g0, busy0, done0, fv0, pass0;
    logic        a1, b1, c1, d1, f1, g1, busy1, done1, fv1, pass1;
    logic [15:0] tt0, tt1;
    logic [4:0]  cnt0, cnt1;
    logic [3:0]  ff0, ff1;
    int          mode0, mode1;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural stand-in for the two function blocks, with planted faults:
    // 0 correct, 1 g inverted at vector 6, 2 both stuck 0, 3 g=~f, 4 both wrong at 15.
    function automatic logic [1:0] fg_model(input int mode, input logic [3:0] v);
        logic [15:0] gold;
        logic f, g;
        gold = 16'hAA45;
        f = gold[v];
        if (mode == 2) f = 1'b0;
        if (mode == 4 && v == 4'd15) f = ~f;
        g = f;
        if (mode == 1 && v == 4'd6) g = ~f;
        if (mode == 3) g = ~f;
        return {f, g};
    endfunction

    assign {f0, g0} = fg_model(mode0, {a0, b0, c0, d0});
    assign {f1, g1} = fg_model(mode1, {a1, b1, c1, d1});

    truth_table_sweeper #(.SETTLE(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .a(a0), .b(b0), .c(c0), .d(d0), .f_in(f0), .g_in(g0),
        .busy(busy0), .done(done0), .truth_table(tt0), .mismatch_cnt(cnt0),
        .fail_valid(fv0), .first_fail(ff0), .pass(pass0)
    );

    truth_table_sweeper #(.SETTLE(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1), .f_in(f1), .g_in(g1),
        .busy(busy1), .done(done1), .truth_table(tt1), .mismatch_cnt(cnt1),
        .fail_valid(fv1), .first_fail(ff1), .pass(pass1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int sel, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(sel == 0 ? done0 : done1) && n < 200);
        chk("done_seen", (sel == 0 ? done0 : done1), 1);
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_done"}, done0, 0);
        chk({tag, "_tt"}, tt0, 0);
        chk({tag, "_cnt"}, cnt0, 0);
        chk({tag, "_fv"}, fv0, 0);
        chk({tag, "_ff"}, ff0, 0);
        chk({tag, "_pass"}, pass0, 0);
        chk({tag, "_abcd"}, {a0, b0, c0, d0}, 0);
    endtask

    typedef struct {
        int          mode;
        logic [15:0] tt;
        logic [4:0]  cnt;
        logic        fv;
        logic [3:0]  ff;
        logic        pass;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, seen, seq_bad;

        tbl[0] = '{mode: 0, tt: 16'hAA45, cnt: 5'd0,  fv: 1'b0, ff: 4'd0,  pass: 1'b1};
        tbl[1] = '{mode: 1, tt: 16'hAA45, cnt: 5'd1,  fv: 1'b1, ff: 4'd6,  pass: 1'b0};
        tbl[2] = '{mode: 2, tt: 16'h0000, cnt: 5'd0,  fv: 1'b1, ff: 4'd0,  pass: 1'b0};
        tbl[3] = '{mode: 3, tt: 16'hAA45, cnt: 5'd16, fv: 1'b1, ff: 4'd0,  pass: 1'b0};
        tbl[4] = '{mode: 4, tt: 16'h2A45, cnt: 5'd0,  fv: 1'b1, ff: 4'd15, pass: 1'b0};

        mode0 = 0; mode1 = 0;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_reset0("reset");

        for (int i = 0; i < 5; i++) begin
            mode0  = tbl[i].mode;
            start0 = 1'b1;
            tick();
            start0 = 1'b0;
            chk($sformatf("v%0d_busy_after_accept", i), busy0, 1);
            wait_done(0, n);
            chk($sformatf("v%0d_latency", i), n, 32);
            chk($sformatf("v%0d_busy_in_done", i), busy0, 0);
            chk($sformatf("v%0d_tt", i), tt0, tbl[i].tt);
            chk($sformatf("v%0d_cnt", i), cnt0, tbl[i].cnt);
            chk($sformatf("v%0d_fv", i), fv0, tbl[i].fv);
            chk($sformatf("v%0d_ff", i), ff0, tbl[i].ff);
            chk($sformatf("v%0d_pass", i), pass0, tbl[i].pass);
            tick();
            chk($sformatf("v%0d_done_one_cycle", i), done0, 0);
            chk($sformatf("v%0d_tt_hold", i), tt0, tbl[i].tt);
            chk($sformatf("v%0d_pass_hold", i), pass0, tbl[i].pass);
        end

        // SETTLE=3: each vector held 4 cycles, a mid-sweep start is ignored.
        mode1  = 0;
        start1 = 1'b1;
        tick();
        start1  = 1'b0;
        n       = 0;
        seq_bad = 0;
        while (!done1 && n < 200) begin
            if (n < 64 && {a1, b1, c1, d1} != 4'(n / 4)) seq_bad++;
            start1 = (n == 10);
            tick();
            n++;
        end
        start1 = 1'b0;
        chk("s3_latency", n, 64);
        chk("s3_vector_sequence_errors", seq_bad, 0);
        chk("s3_tt", tt1, 16'hAA45);
        chk("s3_pass", pass1, 1);

        // Reset while vector 9 is on the bus.
        mode0  = 3;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        k = 0;
        while ({a0, b0, c0, d0} != 4'd9 && k < 100) begin
            tick();
            k++;
        end
        chk("rst_reach_vec9", {a0, b0, c0, d0}, 9);
        chk("rst_pre_cnt", cnt0, 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset0("midrst");
        seen = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (done0) seen++;
        end
        chk("midrst_no_done", seen, 0);
        mode0  = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done(0, n);
        chk("post_rst_latency", n, 32);
        chk("post_rst_pass", pass0, 1);
        chk("post_rst_tt", tt0, 16'hAA45);

        // Reset beats a simultaneous start.
        tick();
        rst = 1'b1; start0 = 1'b1;
        tick();
        rst = 1'b0; start0 = 1'b0;
        chk("rst_vs_start_busy", busy0, 0);
        tick();
        chk("rst_vs_start_idle", busy0, 0);

        // start held high: two sweeps with one IDLE cycle between.
        start0 = 1'b1;
        tick();
        wait_done(0, n);
        chk("held1_latency", n, 32);
        chk("held1_pass", pass0, 1);
        tick();
        chk("held_idle_busy", busy0, 0);
        chk("held_idle_done", done0, 0);
        wait_done(0, n);
        chk("held2_latency", n, 33);
        chk("held2_pass", pass0, 1);
        chk("held2_tt", tt0, 16'hAA45);
        start0 = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
